// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster counters, active-video/sync timing and a frame-synchronous
// matrix double-buffer that commits new transforms only at the start of vertical blanking.
module vga_scan_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic         pclk,
    input  logic         rst,
    output logic [9:0]   h_cnt,
    output logic [9:0]   v_cnt,
    output logic         VGAvalid,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_start,
    output logic         vblank_start,
    input  logic         mtrx_wr_valid,
    output logic         mtrx_wr_ready,
    input  logic [335:0] mtrx_wr_data,
    input  logic [3:0]   mtrx_wr_state,
    output logic [335:0] mtrxIn,
    output logic [3:0]   matrixState
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [0:0] EMPTY   = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    logic [9:0]   h_nxt, v_nxt;
    logic         h_wrap, hs_raw, vs_raw;
    logic [0:0]   state;
    logic [335:0] shadow;
    logic [3:0]   shadow_state;

    always_comb begin
        h_wrap = h_cnt == 10'(H_TOT - 1);
        h_nxt  = h_wrap ? '0 : h_cnt + 10'd1;
        v_nxt  = h_wrap ? (v_cnt == 10'(V_TOT - 1) ? '0 : v_cnt + 10'd1) : v_cnt;
        hs_raw = !(h_cnt >= 10'(H_VIS + H_FP) && h_cnt < 10'(H_VIS + H_FP + H_SYNC));
        vs_raw = !(v_cnt >= 10'(V_VIS + V_FP) && v_cnt < 10'(V_VIS + V_FP + V_SYNC));
    end

    // Qualifiers are built from the next counter values so they line up with h_cnt/v_cnt.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            h_cnt        <= 10'(H_TOT - 1);
            v_cnt        <= 10'(V_TOT - 1);
            VGAvalid     <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
        end else begin
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            VGAvalid     <= h_nxt < 10'(H_VIS) && v_nxt < 10'(V_VIS);
            frame_start  <= h_nxt == 10'd0 && v_nxt == 10'd0;
            vblank_start <= h_nxt == 10'd0 && v_nxt == 10'(V_VIS);
            hsync        <= hs_raw;
            vsync        <= vs_raw;
        end
    end

    assign mtrx_wr_ready = state == EMPTY;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            shadow       <= '0;
            shadow_state <= '0;
            mtrxIn       <= '0;
            matrixState  <= '0;
        end else if (state == EMPTY && mtrx_wr_valid) begin
            state        <= PENDING;
            shadow       <= mtrx_wr_data;
            shadow_state <= mtrx_wr_state;
        end else if (state == PENDING && vblank_start) begin
            state        <= EMPTY;
            mtrxIn       <= shadow;
            matrixState  <= shadow_state;
        end
    end
endmodule
